// File: rtl/mem_io_arbiter_pkg.sv
// mem_io_arbiter_pkg: shared FSM states, owner codes and IO region defaults
package mem_io_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LDR = 1'b1;
  localparam logic [31:0] IO_BASE_DEF = 32'hFFFF_FC00;
  localparam int IO_W_DEF = 24;
endpackage

// File: rtl/mem_io_decode.sv
// mem_io_decode: combinational IO-region match on the upper 22 address bits
module mem_io_decode import mem_io_arbiter_pkg::*; #(
  parameter logic [31:0] IO_BASE = IO_BASE_DEF
) (
  input  logic [31:0] addr,
  output logic        is_io
);
  assign is_io = addr[31:10] == IO_BASE[31:10];
endmodule

// File: rtl/mem_io_arbiter.sv
// mem_io_arbiter: round-robin CPU/loader arbiter sequencing dmem and IO strobes
module mem_io_arbiter import mem_io_arbiter_pkg::*; #(
  parameter logic [31:0] IO_BASE = IO_BASE_DEF,
  parameter int          IO_W    = IO_W_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            c_req,
  input  logic            c_we,
  input  logic [31:0]     c_addr,
  input  logic [31:0]     c_wdata,
  output logic            c_ack,
  output logic [31:0]     c_rdata,
  input  logic            u_req,
  input  logic            u_we,
  input  logic [31:0]     u_addr,
  input  logic [31:0]     u_wdata,
  output logic            u_ack,
  output logic [31:0]     u_rdata,
  output logic [31:0]     m_addr,
  output logic [31:0]     m_wdata,
  output logic            m_we,
  input  logic [31:0]     m_rdata,
  output logic            io_rd,
  output logic            io_wr,
  output logic [IO_W-1:0] io_wdata,
  input  logic [IO_W-1:0] io_rdata,
  output logic            busy,
  output logic            owner
);
  state_t state, nxt;
  logic own, rr, we, is_io, gnt, gnt_ldr, gnt_io;
  logic [31:0] addr, wdata, gnt_addr, rd_in, c_rd, u_rd;
  assign gnt = c_req | u_req;
  assign gnt_ldr = u_req & (~c_req | rr);
  assign gnt_addr = gnt_ldr ? u_addr : c_addr;
  assign rd_in = is_io ? {{(32-IO_W){1'b0}}, io_rdata} : m_rdata;
  mem_io_decode #(.IO_BASE(IO_BASE)) u_decode (.addr(gnt_addr), .is_io(gnt_io));
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:   nxt = gnt ? ACCESS : IDLE;
      ACCESS: nxt = we ? RESP : WAIT;
      WAIT:   nxt = RESP;
      RESP:   nxt = IDLE;
    endcase
    busy  = state != IDLE;
    m_we  = state == ACCESS && we && !is_io;
    io_wr = state == ACCESS && we && is_io;
    io_rd = (state == ACCESS || state == WAIT) && !we && is_io;
    c_ack = state == RESP && own == OWN_CPU;
    u_ack = state == RESP && own == OWN_LDR;
  end
  // Region and direction are frozen at grant; only the owner's rdata register moves.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      own   <= OWN_CPU;
      rr    <= OWN_CPU;
      we    <= 1'b0;
      is_io <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      c_rd  <= '0;
      u_rd  <= '0;
    end else if (state == IDLE && gnt) begin
      own   <= gnt_ldr ? OWN_LDR : OWN_CPU;
      rr    <= ~rr;
      we    <= gnt_ldr ? u_we : c_we;
      is_io <= gnt_io;
      addr  <= gnt_addr;
      wdata <= gnt_ldr ? u_wdata : c_wdata;
    end else if (state == WAIT) begin
      if (own == OWN_LDR) u_rd <= rd_in;
      else c_rd <= rd_in;
    end
  assign owner    = own;
  assign m_addr   = addr;
  assign m_wdata  = wdata;
  assign io_wdata = wdata[IO_W-1:0];
  assign c_rdata  = c_rd;
  assign u_rdata  = u_rd;
endmodule

// File: tb/tb_mem_io_arbiter.sv
// tb_mem_io_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_mem_io_arbiter;
  logic clock = 0, reset = 0;
  logic c_req = 0, c_we = 0, u_req = 0, u_we = 0;
  logic [31:0] c_addr = 0, c_wdata = 0, u_addr = 0, u_wdata = 0;
  logic c_ack, u_ack, m_we, io_rd, io_wr, busy, owner;
  logic [31:0] c_rdata, u_rdata, m_addr, m_wdata, m_rdata;
  logic [23:0] io_wdata, io_rdata = 0, led = 0;
  logic [31:0] tb_mem[256], ref_mem[256];
  logic do_sync = 0;
  int n_checks = 0, n_fail = 0;
  int ack_at, n_ack, busy_at, busy_after, n_mwe, n_iowr, n_iord, n_oack, n_own_bad, iord_mask;
  logic [31:0] we_maddr;
  logic [23:0] wr_iod;

  mem_io_arbiter dut (
    .clock(clock), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_ack(c_ack), .c_rdata(c_rdata),
    .u_req(u_req), .u_we(u_we), .u_addr(u_addr), .u_wdata(u_wdata), .u_ack(u_ack), .u_rdata(u_rdata),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_rdata(m_rdata),
    .io_rd(io_rd), .io_wr(io_wr), .io_wdata(io_wdata), .io_rdata(io_rdata),
    .busy(busy), .owner(owner)
  );

  always #5 clock = ~clock;

  // Synchronous dmem and LED register the arbiter talks to
  always @(posedge clock) begin
    if (do_sync) for (int i = 0; i < 256; i++) tb_mem[i] <= ref_mem[i];
    else if (m_we) tb_mem[m_addr[9:2]] <= m_wdata;
    m_rdata <= tb_mem[m_addr[9:2]];
    if (io_wr) led <= io_wdata;
  end

  task automatic sync_mem;
    do_sync = 1;
    @(negedge clock);
    do_sync = 0;
  endtask

  task automatic set_req(input bit side, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    if (side) begin u_req = r; u_we = w; u_addr = a; u_wdata = d; end
    else begin c_req = r; c_we = w; c_addr = a; c_wdata = d; end
  endtask

  // Runs one request and gathers what the bus did; the scenario tasks judge it
  task automatic run1(input bit side, input bit w, input logic [31:0] a, input logic [31:0] d, input bit drop_early);
    ack_at = -1; n_ack = 0; busy_at = -1; busy_after = -1; n_mwe = 0; n_iowr = 0; n_iord = 0;
    n_oack = 0; n_own_bad = 0; iord_mask = 0; we_maddr = 'x; wr_iod = 'x;
    @(negedge clock);
    set_req(side, 1, w, a, d);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      if (busy && busy_at < 0) busy_at = i;
      if (m_we) begin n_mwe++; we_maddr = m_addr; end
      if (io_wr) begin n_iowr++; wr_iod = io_wdata; end
      if (io_rd) begin n_iord++; iord_mask |= 1 << i; end
      if (busy && owner !== side) n_own_bad++;
      if (side ? c_ack : u_ack) n_oack++;
      if (side ? u_ack : c_ack) begin n_ack++; if (ack_at < 0) ack_at = i; end
      if (ack_at > 0 && i == ack_at + 1) busy_after = busy;
      if ((drop_early && i == 1) || ack_at == i) set_req(side, 0, w, a, d);
    end
  endtask

  task automatic test_reset;
    reset = 0;
    repeat (2) @(negedge clock);
    n_checks++; if ({busy, owner, c_ack, u_ack, m_we, io_rd, io_wr} !== 7'b0) begin n_fail++; $display("FAIL reset_strobes: got %b want 0000000", {busy, owner, c_ack, u_ack, m_we, io_rd, io_wr}); end
    n_checks++; if (c_rdata !== 32'h0 || u_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h want 0/0", c_rdata, u_rdata); end
    n_checks++; if (m_addr !== 32'h0 || m_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_latches: got %h/%h want 0/0", m_addr, m_wdata); end
    reset = 1;
    @(negedge clock);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy %b want 0", busy); end
  endtask

  task automatic test_cpu_mem_read;
    ref_mem[4] = 32'hDEAD_BEEF;
    sync_mem();
    run1(0, 0, 32'h0000_0010, 32'h0, 0);
    n_checks++; if (ack_at !== 3 || n_ack !== 1) begin n_fail++; $display("FAIL cmr_ack: at %0d count %0d want 3/1", ack_at, n_ack); end
    n_checks++; if (c_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL cmr_rdata: got %h want deadbeef", c_rdata); end
    n_checks++; if (n_iord !== 0 || n_mwe !== 0 || n_iowr !== 0) begin n_fail++; $display("FAIL cmr_strobes: iord %0d mwe %0d iowr %0d want 0", n_iord, n_mwe, n_iowr); end
    n_checks++; if (n_oack !== 0) begin n_fail++; $display("FAIL cmr_u_ack: got %0d want 0", n_oack); end
    n_checks++; if (busy_at !== 1 || busy_after !== 0) begin n_fail++; $display("FAIL cmr_busy: rise %0d after %0d want 1/0", busy_at, busy_after); end
  endtask

  task automatic test_cpu_io_write;
    run1(0, 1, 32'hFFFF_FC60, 32'h00AB_CDEF, 0);
    n_checks++; if (n_iowr !== 1 || wr_iod !== 24'hABCDEF) begin n_fail++; $display("FAIL ciw_io_wr: count %0d data %h want 1/abcdef", n_iowr, wr_iod); end
    n_checks++; if (n_mwe !== 0 || n_iord !== 0) begin n_fail++; $display("FAIL ciw_no_mem: mwe %0d iord %0d want 0", n_mwe, n_iord); end
    n_checks++; if (ack_at !== 2 || n_ack !== 1) begin n_fail++; $display("FAIL ciw_ack: at %0d count %0d want 2/1", ack_at, n_ack); end
    n_checks++; if (led !== 24'hABCDEF) begin n_fail++; $display("FAIL ciw_led: got %h want abcdef", led); end
  endtask

  task automatic test_ldr_io_read;
    io_rdata = 24'h123456;
    run1(1, 0, 32'hFFFF_FC70, 32'h0, 0);
    n_checks++; if (iord_mask !== 32'b110) begin n_fail++; $display("FAIL lir_io_rd: cycles %b want 110", iord_mask); end
    n_checks++; if (u_rdata !== 32'h0012_3456) begin n_fail++; $display("FAIL lir_rdata: got %h want 00123456", u_rdata); end
    n_checks++; if (n_own_bad !== 0 || busy_at !== 1) begin n_fail++; $display("FAIL lir_owner: bad %0d rise %0d want 0/1", n_own_bad, busy_at); end
    n_checks++; if (ack_at !== 3 || n_oack !== 0 || n_mwe !== 0) begin n_fail++; $display("FAIL lir_ack: at %0d c_ack %0d mwe %0d want 3/0/0", ack_at, n_oack, n_mwe); end
    n_checks++; if (c_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lir_cpu_hold: got %h want deadbeef", c_rdata); end
  endtask

  task automatic test_req_drop;
    run1(0, 1, 32'h0000_0040, 32'h0000_0001, 1);
    n_checks++; if (n_mwe !== 1 || we_maddr !== 32'h40) begin n_fail++; $display("FAIL drop_mwe: count %0d addr %h want 1/40", n_mwe, we_maddr); end
    n_checks++; if (ack_at !== 2 || n_ack !== 1) begin n_fail++; $display("FAIL drop_ack: at %0d count %0d want 2/1", ack_at, n_ack); end
    n_checks++; if (tb_mem[16] !== 32'h1 || n_iowr !== 0) begin n_fail++; $display("FAIL drop_mem: got %h iowr %0d want 1/0", tb_mem[16], n_iowr); end
  endtask

  task automatic test_round_robin;
    int ng, na, rises;
    logic g[4], a[4];
    logic prev;
    ng = 0; na = 0; rises = 0; prev = 0;
    @(negedge clock);
    reset = 0;
    set_req(0, 1, 1, 32'h100, 32'hC0C0_0001);
    set_req(1, 1, 1, 32'h104, 32'h1D1D_0002);
    @(negedge clock);
    reset = 1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clock);
      if (busy && !prev) begin rises++; if (ng < 4) g[ng++] = owner; end
      if (c_ack && na < 4) a[na++] = 1'b0;
      if (u_ack && na < 4) a[na++] = 1'b1;
      prev = busy;
    end
    c_req = 0; u_req = 0;
    @(negedge clock);
    n_checks++; if (ng !== 4 || rises !== 4) begin n_fail++; $display("FAIL rr_grants: %0d grants %0d busy periods want 4/4", ng, rises); end
    n_checks++; if (ng == 4 && {g[0], g[1], g[2], g[3]} !== 4'b0101) begin n_fail++; $display("FAIL rr_order: got %b want 0101", {g[0], g[1], g[2], g[3]}); end
    n_checks++; if (na !== 4 || {a[0], a[1], a[2], a[3]} !== 4'b0101) begin n_fail++; $display("FAIL rr_acks: count %0d order %b want 4/0101", na, {a[0], a[1], a[2], a[3]}); end
    n_checks++; if (tb_mem[64] !== 32'hC0C0_0001 || tb_mem[65] !== 32'h1D1D_0002) begin n_fail++; $display("FAIL rr_mem: got %h/%h want c0c00001/1d1d0002", tb_mem[64], tb_mem[65]); end
  endtask

  task automatic test_reset_mid;
    @(negedge clock);
    set_req(0, 1, 0, 32'h0000_0010, 32'h0);
    repeat (2) @(negedge clock);
    n_checks++; if (busy !== 1'b1 || c_ack !== 1'b0) begin n_fail++; $display("FAIL rm_in_wait: busy %b ack %b want 1/0", busy, c_ack); end
    reset = 0;
    #1;
    n_checks++; if ({busy, owner, c_ack, u_ack, m_we, io_rd, io_wr} !== 7'b0) begin n_fail++; $display("FAIL rm_abort: got %b want 0000000", {busy, owner, c_ack, u_ack, m_we, io_rd, io_wr}); end
    n_checks++; if (c_rdata !== 32'h0) begin n_fail++; $display("FAIL rm_rdata: got %h want 0", c_rdata); end
    set_req(0, 1, 1, 32'h80, 32'h5);
    set_req(1, 1, 1, 32'h84, 32'h6);
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    n_checks++; if (busy !== 1'b1 || owner !== 1'b0) begin n_fail++; $display("FAIL rm_first_grant: busy %b owner %b want 1/0", busy, owner); end
    u_req = 0;
    @(negedge clock);
    n_checks++; if (c_ack !== 1'b1 || u_ack !== 1'b0) begin n_fail++; $display("FAIL rm_ack: c %b u %b want 1/0", c_ack, u_ack); end
    c_req = 0;
    repeat (2) @(negedge clock);
  endtask

  // Transaction-level model: grant by request levels and a flip-on-grant pointer,
  // fixed phase timing per read/write, memory and LED contents tracked per transaction
  task automatic test_random;
    logic rq[2], rwe[2], dropped[2];
    logic [31:0] ra[2], rd[2], exp_rd[2], ca, cw, cexp;
    logic [23:0] exp_led;
    logic rr_m, active, post_ack, co, cwe, cio, exp_own;
    int k, ackk, n_txn;
    rq = '{0, 0}; exp_rd = '{32'h0, 32'h0}; rr_m = 0; active = 0; post_ack = 0; k = 0; n_txn = 0;
    exp_led = led; co = 0; cwe = 0; cio = 0; ca = 0; cw = 0; cexp = 0; ackk = 0;
    @(negedge clock);
    reset = 0;
    c_req = 0; u_req = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
    sync_mem();
    io_rdata = 24'($urandom);
    reset = 1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clock);
      dropped = '{0, 0};
      if (post_ack) begin
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rnd_gap: busy %b want 0 at cycle %0d", busy, cyc); end
        post_ack = 0;
      end else if (!active && busy) begin
        exp_own = (rq[0] && rq[1]) ? rr_m : rq[1];
        n_checks++; if (owner !== exp_own) begin n_fail++; $display("FAIL rnd_grant: owner %b want %b at cycle %0d", owner, exp_own, cyc); end
        rr_m = !rr_m;
        active = 1; k = 1; n_txn++;
        co = exp_own; cwe = rwe[co]; ca = ra[co]; cw = rd[co];
        cio = ca[31:10] == 22'h3F_FFFF;
        ackk = cwe ? 2 : 3;
        if (cwe && !cio) ref_mem[ca[9:2]] = cw;
        if (cwe && cio) exp_led = cw[23:0];
        cexp = cio ? {8'h00, io_rdata} : ref_mem[ca[9:2]];
      end else if (!active && (rq[0] || rq[1])) begin
        n_checks++; n_fail++; $display("FAIL rnd_missed_grant: busy %b want 1 at cycle %0d", busy, cyc);
      end
      if (active) begin
        n_checks++; if (busy !== 1'b1 || owner !== co) begin n_fail++; $display("FAIL rnd_busy: busy %b owner %b want 1/%b at cycle %0d", busy, owner, co, cyc); end
        n_checks++; if ({m_we, io_wr, io_rd} !== {k == 1 && cwe && !cio, k == 1 && cwe && cio, !cwe && cio && k <= 2}) begin n_fail++; $display("FAIL rnd_strobes: mwe/iowr/iord %b want %b phase %0d cycle %0d", {m_we, io_wr, io_rd}, {k == 1 && cwe && !cio, k == 1 && cwe && cio, !cwe && cio && k <= 2}, k, cyc); end
        n_checks++; if ({c_ack, u_ack} !== {k == ackk && !co, k == ackk && co}) begin n_fail++; $display("FAIL rnd_ack: c/u %b want %b phase %0d cycle %0d", {c_ack, u_ack}, {k == ackk && !co, k == ackk && co}, k, cyc); end
        if (k == 1) begin
          n_checks++; if (m_addr !== ca || m_wdata !== cw || io_wdata !== cw[23:0]) begin n_fail++; $display("FAIL rnd_bus: addr %h data %h want %h/%h cycle %0d", m_addr, m_wdata, ca, cw, cyc); end
        end
        if (k == ackk) begin
          if (!cwe) exp_rd[co] = cexp;
          if (cwe && cio) begin n_checks++; if (led !== exp_led) begin n_fail++; $display("FAIL rnd_led: got %h want %h cycle %0d", led, exp_led, cyc); end end
          if (cwe && !cio) begin n_checks++; if (tb_mem[ca[9:2]] !== cw) begin n_fail++; $display("FAIL rnd_mem: got %h want %h cycle %0d", tb_mem[ca[9:2]], cw, cyc); end end
          rq[co] = 0; dropped[co] = 1; active = 0; post_ack = 1;
        end
        k++;
      end else begin
        n_checks++; if ({m_we, io_wr, io_rd, c_ack, u_ack} !== 5'b0) begin n_fail++; $display("FAIL rnd_idle_strobes: got %b want 00000 cycle %0d", {m_we, io_wr, io_rd, c_ack, u_ack}, cyc); end
      end
      n_checks++; if (c_rdata !== exp_rd[0] || u_rdata !== exp_rd[1]) begin n_fail++; $display("FAIL rnd_rdata: got %h/%h want %h/%h cycle %0d", c_rdata, u_rdata, exp_rd[0], exp_rd[1], cyc); end
      for (int s = 0; s < 2; s++)
        if (!rq[s] && !dropped[s] && $urandom_range(0, 3) == 0) begin
          rq[s] = 1; rwe[s] = 1'($urandom); rd[s] = $urandom;
          ra[s] = ($urandom_range(0, 2) == 0) ? {22'h3F_FFFF, 10'($urandom)} : {22'h0, 8'($urandom), 2'($urandom)};
        end
      if (!busy) io_rdata = 24'($urandom);
      set_req(0, rq[0], rwe[0], ra[0], rd[0]);
      set_req(1, rq[1], rwe[1], ra[1], rd[1]);
    end
    c_req = 0; u_req = 0;
    repeat (4) @(negedge clock);
    n_checks++; if (n_txn < 100) begin n_fail++; $display("FAIL rnd_traffic: %0d transactions want at least 100", n_txn); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    test_reset();
    sync_mem();
    test_cpu_mem_read();
    test_cpu_io_write();
    test_ldr_io_read();
    test_req_drop();
    test_round_robin();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_io_arbiter.md
Name: mem_io_arbiter

Overview:
Two-requester arbiter and sequencer for the shared data-memory / memory-mapped-IO datapath. Requester 0 is the CPU load/store path. Requester 1 is the UART program/data loader. The block grants one requester at a time, decodes the address into the memory or IO region, and drives the dmem strobes or the IO chip-select strobes with a fixed cycle sequence. It returns read data and a one-cycle ack to the requester that owns the grant.

Parameters:
IO_BASE, 32'hFFFF_FC00, base of the IO region; match is on addr[31:10] == IO_BASE[31:10]
IO_W, 24, IO data width (LED/switch bus)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
c_req  in  1  CPU request, level
c_we  in  1  CPU write (1) / read (0)
c_addr  in  32  CPU byte address
c_wdata  in  32  CPU write data
c_ack  out  1  CPU completion pulse
c_rdata  out  32  CPU read data, valid when c_ack=1
u_req, u_we, u_addr, u_wdata  in  1/1/32/32  loader request, same semantics as CPU
u_ack, u_rdata  out  1/32  loader completion and read data
m_addr  out  32  dmem address
m_wdata  out  32  dmem write data
m_we  out  1  dmem write enable
m_rdata  in  32  dmem read data, synchronous (valid the cycle after the address)
io_rd  out  1  switch chip select (read)
io_wr  out  1  LED chip select (write)
io_wdata  out  IO_W  IO write data = latched wdata[23:0]
io_rdata  in  IO_W  IO read data
busy  out  1  transaction in progress
owner  out  1  0 = CPU, 1 = loader; meaningful while busy=1

Behaviour:
- Reset (async, reset=0): state IDLE, rr pointer = CPU, latched addr/wdata/we = 0, rdata registers = 0. All strobes, acks, busy and owner are 0. The effect is immediate, including mid-transaction; no ack is issued for an aborted transaction.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE: if no request, stay. If one request, grant it. If both, grant the rr pointer's side.
  - On grant: latch addr/we/wdata, set owner, set is_io = region match, go to ACCESS.
  - The rr pointer flips to the other side on every grant.
- ACCESS (1 cycle): busy=1.
  - Memory write: m_we=1.
  - IO write: io_wr=1.
  - Memory read: address presented.
  - IO read: io_rd=1.
  - Writes then go to RESP; reads go to WAIT.
- WAIT (reads only, 1 cycle): io_rd held 1 for IO reads. At the end of WAIT, capture m_rdata, or {8'b0, io_rdata}, into the owner's rdata register.
- RESP (1 cycle): owner's ack=1, then go to IDLE. The next request may be sampled in the IDLE cycle that follows.
- Latency from the grant edge to ack: writes 2 cycles, reads 3 cycles. Minimum request spacing is 3 cycles (writes) or 4 cycles (reads).
- m_addr and m_wdata are always driven from the latched registers. m_we and io_wr are high for exactly one cycle per write, never both, and never for reads.
- The region decision is made once at grant. Memory accesses never assert io_*; IO accesses never assert m_we.
- Requests are latched. Deasserting req mid-transaction does not abort; ack is still issued. Requesters must drop req in their ack cycle. A req still high in IDLE is treated as a new transaction.
- Non-owner ack stays 0. The non-owner rdata register holds its previous value.
- addr[1:0] is passed through unchecked. No byte enables.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, RESP=2'd3)
  - owner codes (OWN_CPU=1'b0, OWN_LDR=1'b1)
  - IO_BASE default and IO_W
- One sub-module, mem_io_decode: purely combinational region match (addr -> is_io). It is reused by the CPU-side memory/IO steering.

Test Plan:
- CPU read addr 0x0000_0010, dmem model returns 0xDEADBEEF -> c_ack high exactly 3 cycles after grant, c_rdata=0xDEADBEEF, io_rd never 1, u_ack stays 0.
- CPU write addr 0xFFFF_FC60, wdata 0x00AB_CDEF -> io_wr=1 for one cycle with io_wdata=0xABCDEF, m_we never 1, c_ack 2 cycles after grant.
- Loader read addr 0xFFFF_FC70, io_rdata=0x123456 -> io_rd high in ACCESS and WAIT, u_rdata=0x0012_3456, owner=1 throughout.
- c_req and u_req held high from reset for four transactions -> grant order CPU, loader, CPU, loader; acks alternate; no overlapping busy periods.
- reset driven low during WAIT of a CPU read -> all strobes, busy and c_ack 0 immediately; after release, the first simultaneous request is granted to CPU.
- c_req dropped in the cycle after grant (memory write, addr 0x40, data 0x1) -> m_we pulse still occurs with m_addr=0x40, c_ack still issued.
